// File: rtl/ch_config_writer.sv
// Byte-serial initiator for the channel config bus: queues multi-byte parameter
// commands and replays each as LSB-first single-byte writes at incrementing addresses.
module ch_config_writer #(
    parameter int GAP_CYCLES = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK_LOW,
    input  logic                          reset,
    input  logic                          CMD_VALID,
    output logic                          CMD_READY,
    input  logic [7:0]                    CMD_ADDR,
    input  logic [2:0]                    CMD_LEN,
    input  logic [47:0]                   CMD_DATA,
    output logic                          CH_CONFIG_WE,
    output logic [7:0]                    CH_CONFIG_ADDR,
    output logic [7:0]                    CH_CONFIG_DATA,
    output logic                          CMD_DONE,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // state | meaning
    // IDLE  | pop next command, launch first byte or finish an empty one
    // WRITE | WE high for this cycle
    // GAP   | inter-byte idle, down-counter running
    typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

    logic [7:0]  mem_addr [FIFO_DEPTH];
    logic [2:0]  mem_len  [FIFO_DEPTH];
    logic [47:0] mem_data [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] level;
    logic        full, empty, push, pop;
    logic [2:0]  len_clamped;

    logic [7:0]  head_addr;
    logic [2:0]  head_len;
    logic [47:0] head_data;

    state_t      state, state_n;
    logic [47:0] payload, payload_n;
    logic [2:0]  rem, rem_n;
    logic [3:0]  gap_cnt, gap_n;
    logic        we_q, we_n;
    logic [7:0]  addr_q, addr_n;
    logic [7:0]  data_q, data_n;
    logic        done_q, done_n;

    assign level       = wr_ptr - rd_ptr;
    assign full        = (level == (AW+1)'(FIFO_DEPTH));
    assign empty       = (wr_ptr == rd_ptr);
    assign push        = CMD_VALID && !full;
    assign pop         = (state == IDLE) && !empty;
    assign len_clamped = (CMD_LEN > 3'd6) ? 3'd6 : CMD_LEN;

    assign head_addr = mem_addr[rd_ptr[AW-1:0]];
    assign head_len  = mem_len[rd_ptr[AW-1:0]];
    assign head_data = mem_data[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK_LOW) begin
        if (push) begin
            mem_addr[wr_ptr[AW-1:0]] <= CMD_ADDR;
            mem_len[wr_ptr[AW-1:0]]  <= len_clamped;
            mem_data[wr_ptr[AW-1:0]] <= CMD_DATA;
        end
    end

    always_ff @(posedge CLK_LOW or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK_LOW or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            payload <= '0;
            rem     <= '0;
            gap_cnt <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            payload <= payload_n;
            rem     <= rem_n;
            gap_cnt <= gap_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        payload_n = payload;
        rem_n     = rem;
        gap_n     = gap_cnt;
        we_n      = 1'b0;
        addr_n    = addr_q;
        data_n    = data_q;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (head_len == 3'd0) begin
                        done_n = 1'b1;
                    end else begin
                        we_n      = 1'b1;
                        addr_n    = head_addr;
                        data_n    = head_data[7:0];
                        payload_n = head_data >> 8;
                        rem_n     = head_len;
                        state_n   = WRITE;
                    end
                end
            end
            WRITE: begin
                rem_n = rem - 3'd1;
                if (rem == 3'd1) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (GAP_CYCLES == 0) begin
                    we_n      = 1'b1;
                    addr_n    = addr_q + 8'd1;
                    data_n    = payload[7:0];
                    payload_n = payload >> 8;
                end else begin
                    gap_n   = GAP_LOAD;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    we_n      = 1'b1;
                    addr_n    = addr_q + 8'd1;
                    data_n    = payload[7:0];
                    payload_n = payload >> 8;
                    state_n   = WRITE;
                end else begin
                    gap_n = gap_cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign CMD_READY      = !full;
    assign CH_CONFIG_WE   = we_q;
    assign CH_CONFIG_ADDR = addr_q;
    assign CH_CONFIG_DATA = data_q;
    assign CMD_DONE       = done_q;
    assign BUSY           = (state != IDLE) || !empty;
    assign FIFO_LEVEL     = level;

endmodule

// File: tb/tb_ch_config_writer.sv
// Scoreboard bench: three writers (gap 1, 0, 3) exercised one at a time; the driver
// queues the expected bus events, per-instance monitors pop and check them.
module tb_ch_config_writer;

    function automatic int gap_of(int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    typedef struct {
        int         dut;
        bit         is_done;
        bit         first;
        bit         after_write;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [3];
    logic        cmd_valid [3];
    logic        cmd_ready [3];
    logic [7:0]  cmd_addr  [3];
    logic [2:0]  cmd_len   [3];
    logic [47:0] cmd_data  [3];
    logic        we        [3];
    logic [7:0]  ch_addr   [3];
    logic [7:0]  ch_data   [3];
    logic        done      [3];
    logic        busy      [3];
    logic [2:0]  level     [3];

    int  wr_seen   [3];
    int  done_seen [3];
    int  nr_cnt    [3];
    int  cyc;
    int  total;
    int  bad;
    ev_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ch_config_writer #(.GAP_CYCLES(gap_of(g)), .FIFO_DEPTH(4)) dut (
            .CLK_LOW        (clk),
            .reset          (rst[g]),
            .CMD_VALID      (cmd_valid[g]),
            .CMD_READY      (cmd_ready[g]),
            .CMD_ADDR       (cmd_addr[g]),
            .CMD_LEN        (cmd_len[g]),
            .CMD_DATA       (cmd_data[g]),
            .CH_CONFIG_WE   (we[g]),
            .CH_CONFIG_ADDR (ch_addr[g]),
            .CH_CONFIG_DATA (ch_data[g]),
            .CMD_DONE       (done[g]),
            .BUSY           (busy[g]),
            .FIFO_LEVEL     (level[g])
        );

        int         last_we = 0;
        bit         have_we = 0;
        logic [7:0] last_a  = 8'h00;
        logic [7:0] last_d  = 8'h00;
        ev_t        e;

        always @(negedge clk) begin
            if (rst[g] !== 1'b0) begin
                last_a = 8'h00;
                last_d = 8'h00;
            end else begin
                chk($sformatf("level_max%0d", g), 64'(level[g] <= 3'd4), 64'd1);
                chk($sformatf("ready_vs_level%0d", g), 64'(cmd_ready[g]), 64'(level[g] != 3'd4));
                if (!cmd_ready[g]) nr_cnt[g]++;
                if (we[g]) begin
                    wr_seen[g]++;
                    if (exp_q.size() == 0) begin
                        chk($sformatf("unexpected_write%0d", g), {48'd0, ch_addr[g], ch_data[g]}, 64'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("write_kind%0d", g), {e.dut[31:0], 31'd0, e.is_done}, {32'(g), 32'd0});
                        chk($sformatf("write_addr_data%0d", g), {48'd0, ch_addr[g], ch_data[g]}, {48'd0, e.addr, e.data});
                        if (!e.first)
                            chk($sformatf("byte_spacing%0d", g), 64'(cyc - last_we), 64'(gap_of(g) + 1));
                        else if (have_we)
                            chk($sformatf("cmd_spacing_min%0d", g), 64'((cyc - last_we) >= 2), 64'd1);
                    end
                    last_we = cyc;
                    have_we = 1;
                    last_a  = ch_addr[g];
                    last_d  = ch_data[g];
                end else begin
                    chk($sformatf("bus_hold%0d", g), {48'd0, ch_addr[g], ch_data[g]}, {48'd0, last_a, last_d});
                end
                if (done[g]) begin
                    done_seen[g]++;
                    if (exp_q.size() == 0) begin
                        chk($sformatf("unexpected_done%0d", g), 64'(done[g]), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("done_kind%0d", g), {e.dut[31:0], 31'd0, e.is_done}, {32'(g), 32'd1});
                        if (e.after_write)
                            chk($sformatf("done_timing%0d", g), 64'(cyc - last_we), 64'd1);
                    end
                end
            end
        end
    end

    task automatic push_expected(int i, logic [7:0] a, logic [2:0] l, logic [47:0] d);
        int  n;
        ev_t ev;
        n = (l > 3'd6) ? 6 : int'(l);
        for (int b = 0; b < n; b++) begin
            ev.dut = i; ev.is_done = 0; ev.first = (b == 0); ev.after_write = 0;
            ev.addr = a + 8'(b);
            ev.data = d[8*b +: 8];
            exp_q.push_back(ev);
        end
        ev.dut = i; ev.is_done = 1; ev.first = 0; ev.after_write = (n > 0);
        ev.addr = 8'h00; ev.data = 8'h00;
        exp_q.push_back(ev);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with VALID still high.
    task automatic send(int i, logic [7:0] a, logic [2:0] l, logic [47:0] d);
        int g;
        cmd_addr[i]  = a;
        cmd_len[i]   = l;
        cmd_data[i]  = d;
        cmd_valid[i] = 1'b1;
        g = 0;
        while (!cmd_ready[i] && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) begin
            chk("accept_timeout", 64'd0, 64'd1);
            cmd_valid[i] = 1'b0;
        end else begin
            push_expected(i, a, l, d);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_drain(int i);
        bit ok;
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !busy[i]) begin
                ok = 1;
                break;
            end
        end
        chk($sformatf("drain%0d", i), 64'(ok), 64'd1);
    endtask

    task automatic check_reset_state(int i, string tag);
        chk({tag, "_we"},    64'(we[i]),      64'd0);
        chk({tag, "_addr"},  64'(ch_addr[i]), 64'd0);
        chk({tag, "_data"},  64'(ch_data[i]), 64'd0);
        chk({tag, "_done"},  64'(done[i]),    64'd0);
        chk({tag, "_level"}, 64'(level[i]),   64'd0);
        chk({tag, "_busy"},  64'(busy[i]),    64'd0);
        chk({tag, "_ready"}, 64'(cmd_ready[i]), 64'd1);
    endtask

    task automatic random_cmds(int i, int count);
        for (int n = 0; n < count; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                cmd_valid[i] = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
            send(i, 8'($urandom), 3'($urandom_range(0, 7)), {16'($urandom), 32'($urandom)});
        end
        cmd_valid[i] = 1'b0;
        wait_drain(i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0, n0;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; cmd_valid[i] = 1'b0;
            cmd_addr[i] = '0; cmd_len[i] = '0; cmd_data[i] = '0;
        end
        #12;
        for (int i = 0; i < 3; i++) check_reset_state(i, $sformatf("rst%0d", i));
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        @(negedge clk);

        // frequency increment, plus first-write latency
        send(0, 8'h03, 3'd6, 48'h1234_5678_9ABC);
        cmd_valid[0] = 1'b0;
        #1;
        chk("latency_we_low", 64'(we[0]), 64'd0);
        @(negedge clk); #1;
        chk("latency_we_high", 64'(we[0]), 64'd1);
        chk("latency_addr", 64'(ch_addr[0]), 64'h03);
        wait_drain(0);

        // backpressure with VALID held high
        w0 = wr_seen[0]; d0 = done_seen[0]; n0 = nr_cnt[0];
        for (int k = 0; k < 10; k++) send(0, 8'h40 + 8'(k), 3'd1, 48'(8'hA0 + 8'(k)));
        cmd_valid[0] = 1'b0;
        wait_drain(0);
        chk("bp_ready_low_seen", 64'(nr_cnt[0] > n0), 64'd1);
        chk("bp_writes", 64'(wr_seen[0] - w0), 64'd10);
        chk("bp_dones", 64'(done_seen[0] - d0), 64'd10);

        // zero-length and clamped length
        w0 = wr_seen[0]; d0 = done_seen[0];
        send(0, 8'h2D, 3'd0, 48'hFFFF_FFFF_FFFF);
        cmd_valid[0] = 1'b0;
        wait_drain(0);
        chk("len0_writes", 64'(wr_seen[0] - w0), 64'd0);
        chk("len0_dones", 64'(done_seen[0] - d0), 64'd1);
        w0 = wr_seen[0];
        send(0, 8'h03, 3'd7, 48'hFEDC_BA98_7654);
        cmd_valid[0] = 1'b0;
        wait_drain(0);
        chk("len7_writes", 64'(wr_seen[0] - w0), 64'd6);

        // address wrap
        send(0, 8'hFE, 3'd3, 48'h0000_00CC_BBAA);
        cmd_valid[0] = 1'b0;
        wait_drain(0);

        random_cmds(0, 40);

        // reset in the middle of a command with two more queued
        w0 = wr_seen[0];
        send(0, 8'h10, 3'd6, 48'h6655_4433_2211);
        send(0, 8'h20, 3'd2, 48'h0000_0000_B2B1);
        send(0, 8'h28, 3'd2, 48'h0000_0000_C2C1);
        cmd_valid[0] = 1'b0;
        for (int k = 0; k < 200 && wr_seen[0] < w0 + 2; k++) begin
            @(negedge clk);
            #1;
        end
        chk("mid_reset_reached", 64'(wr_seen[0] - w0), 64'd2);
        d0 = done_seen[0];
        rst[0] = 1'b1;
        #1;
        exp_q.delete();
        check_reset_state(0, "midrst");
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        chk("midrst_no_done", 64'(done_seen[0] - d0), 64'd0);
        chk("midrst_no_write", 64'(wr_seen[0] - w0), 64'd2);
        send(0, 8'h31, 3'd1, 48'h77);
        cmd_valid[0] = 1'b0;
        wait_drain(0);

        // gap 0 and gap 3 instances
        for (int i = 1; i < 3; i++) begin
            w0 = wr_seen[i];
            send(i, 8'h46, 3'd2, 48'h5511);
            cmd_valid[i] = 1'b0;
            wait_drain(i);
            chk($sformatf("gap_writes%0d", i), 64'(wr_seen[i] - w0), 64'd2);
            random_cmds(i, 25);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ch_config_writer.md
Name: ch_config_writer

Overview:
- Initiator side of the per-channel byte-wide config bus (CH_CONFIG_WE / CH_CONFIG_ADDR / CH_CONFIG_DATA) that feeds the channel register block.
- Accepts multi-byte parameter commands (start address, length 0..6, 48-bit payload) over a valid/ready handshake and buffers them in a small command FIFO.
- Serialises each command into consecutive single-byte writes, LSB first, with incrementing address.
- Typical use: the 48-bit frequency increment at 03..08, where the last byte commits, and PRBS multi-byte fields at 42..4A.

Parameters:
- GAP_CYCLES, default 1: idle cycles (WE low) inserted between bytes of one command. Range 0..15.
- FIFO_DEPTH, default 4: command FIFO entries. Must be a power of 2, at least 2.

Ports:
- CLK_LOW  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  FIFO can accept a command; equals not full.
- CMD_ADDR  in  8  address of the first byte.
- CMD_LEN  in  3  byte count; 0 = no writes; values above 6 clamp to 6.
- CMD_DATA  in  48  payload; byte i = CMD_DATA[8i+7:8i].
- CH_CONFIG_WE  out  1  write strobe, one cycle per byte.
- CH_CONFIG_ADDR  out  8  write address.
- CH_CONFIG_DATA  out  8  write data.
- CMD_DONE  out  1  one-cycle pulse when a command completes.
- BUSY  out  1  engine not IDLE, or FIFO not empty.
- FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  stored command count.

Behaviour:
- Reset (asynchronous, immediate): CH_CONFIG_WE=0, CH_CONFIG_ADDR=0, CH_CONFIG_DATA=0, CMD_DONE=0, FIFO empty, FIFO_LEVEL=0, BUSY=0, state=IDLE. CMD_READY reads 1 while and after reset.
- Handshake: a command is accepted on the edge where CMD_VALID=1 and CMD_READY=1. The length is clamped on entry. CMD_VALID while not ready is ignored, with no loss. Push and pop on the same edge leave the level unchanged. FIFO order is strict.
- All bus outputs are registered. ADDR and DATA hold their last value while WE=0.
- Engine FSM:
  - IDLE: if the FIFO is not empty, pop the head and load addr, data, rem=len.
    - rem=0: pulse CMD_DONE next cycle, stay IDLE.
    - Otherwise: drive WE=1, ADDR=addr, DATA=byte0, go to WRITE.
  - WRITE: WE is high for exactly this cycle. On the next edge rem is decremented.
    - rem becomes 0: WE=0, CMD_DONE=1 for one cycle, go to IDLE.
    - Else if GAP_CYCLES=0: stay in WRITE, WE stays 1, ADDR+1, next byte.
    - Else: WE=0, load gap counter with GAP_CYCLES, go to GAP.
  - GAP: decrement the counter; at terminal count drive WE=1, ADDR+1, next byte, go to WRITE.
- Latency: command accepted at edge k into an empty FIFO with the engine IDLE → first WE high in the cycle after edge k+1.
- Timing for N bytes: N WE pulses with GAP_CYCLES low cycles between them. CMD_DONE is high in the cycle right after the last WE cycle.
- Between commands there is a minimum of 1 WE-low cycle (the IDLE pop cycle), independent of GAP_CYCLES. This guarantees the receiver's commit flag clears.
- Address arithmetic is 8-bit modulo: FF+1=00.
- Payload is shifted right by 8 per byte; only the lower len bytes are emitted.
- Reset mid-command: the partial command and all FIFO contents are discarded, with no CMD_DONE. The engine restarts cleanly from IDLE after reset deasserts.

Test Plan:
1. GAP=1, command ADDR=03, LEN=6, DATA=0x123456789ABC → writes (03,BC),(04,9A),(05,78),(06,56),(07,34),(08,12). Each WE pulse is 1 cycle with 1 low cycle between. CMD_DONE pulses in the cycle after the 08 write. First WE is 1 cycle after the accept edge.
2. Ten LEN=1 commands with ADDR 40..49, DATA 0xA0..0xA9, CMD_VALID held high, FIFO_DEPTH=4 → CMD_READY low for at least 1 cycle, FIFO_LEVEL never exceeds 4. Exactly ten writes in order with no duplicates, 1 low cycle between them, ten CMD_DONE pulses.
3. LEN=0, ADDR=2D → no WE, one CMD_DONE pulse. LEN=7, ADDR=03 → exactly six writes, 03..08.
4. ADDR=FE, LEN=3, DATA=0x000000CCBBAA → writes (FE,AA),(FF,BB),(00,CC).
5. Reset asserted after the 2nd write of a LEN=6 command, with 2 commands queued → WE=0 immediately, FIFO_LEVEL=0, CMD_READY=1, no CMD_DONE. After release, a new LEN=1 command at 31 writes normally.
6. GAP_CYCLES=0, ADDR=46, LEN=2, DATA=0x5511 → WE high for 2 consecutive cycles: (46,11),(47,55). GAP_CYCLES=3 → 3 low cycles between the same two writes.
